// File: rtl/game_pkg.sv
// Shared encodings and default timing for the whack-a-mole game sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StCountdown = 2'b01,
    StPlaying   = 2'b10,
    StGameOver  = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    DiffEasy   = 2'b00,
    DiffMedium = 2'b01,
    DiffHard   = 2'b10
  } difficulty_e;

  localparam int unsigned CountdownLenDefault = 5;
  localparam int unsigned GameLenDefault      = 30;

endpackage

// File: rtl/game_control_fsm_edge_detect.sv
// Rising-edge pulse generator for a debounced button level.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/game_control_fsm.sv
// Top-level game sequencer: IDLE -> COUNTDOWN -> PLAYING -> GAME_OVER, with clear
// handshakes to the external counters and display selection.
module game_control_fsm
  import game_pkg::*;
#(
  parameter int unsigned COUNTDOWN_LEN = CountdownLenDefault,
  parameter int unsigned GAME_LEN      = GameLenDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_1hz,
  input  logic       btn_reset,
  input  logic       btn_reset_score,
  input  logic [1:0] btn_difficulty,
  input  logic       timeout_pulse,
  input  logic       hit_pulse,
  input  logic [5:0] countdown_sec,
  input  logic [5:0] game_time_sec,
  input  logic [7:0] score,
  output logic       enable_countdown,
  output logic       clear_countdown,
  output logic       enable_game_timer,
  output logic       clear_game_timer,
  output logic       enable_score,
  output logic       clear_score,
  output logic       enable_mole_ctrl,
  output logic       enable_difficulty_timer,
  output logic [1:0] difficulty_level,
  output logic [7:0] display_value,
  output logic       display_mode,
  output logic [1:0] game_state
);

  localparam logic [7:0] CdLen   = 8'(COUNTDOWN_LEN);
  localparam logic [7:0] GameLen = 8'(GAME_LEN);

  // Informational inputs; kept on the port list for the surrounding system.
  logic unused_inputs;
  assign unused_inputs = ^{clk_1hz, timeout_pulse, hit_pulse};

  logic rst_edge, rst_score_edge;

  edge_detect u_edge_reset (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_reset),
    .pulse (rst_edge)
  );

  edge_detect u_edge_reset_score (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_reset_score),
    .pulse (rst_score_edge)
  );

  game_state_e state_q, state_d;
  difficulty_e diff_q, diff_d;
  logic clr_cd_q, clr_cd_d;
  logic clr_gt_q, clr_gt_d;
  logic clr_sc_q, clr_sc_d;

  logic [7:0] cd_sec;
  logic [7:0] gt_sec;
  assign cd_sec = {2'b00, countdown_sec};
  assign gt_sec = {2'b00, game_time_sec};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      diff_q   <= DiffEasy;
      clr_cd_q <= 1'b0;
      clr_gt_q <= 1'b0;
      clr_sc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      diff_q   <= diff_d;
      clr_cd_q <= clr_cd_d;
      clr_gt_q <= clr_gt_d;
      clr_sc_q <= clr_sc_d;
    end
  end

  // Clear flags hold until their counter reads zero; a fresh edge re-arms them.
  always_comb begin
    clr_cd_d = clr_cd_q && (countdown_sec != 6'd0);
    clr_gt_d = clr_gt_q && (game_time_sec != 6'd0);
    clr_sc_d = clr_sc_q && (score != 8'd0);
    if (rst_edge) begin
      clr_cd_d = 1'b1;
      clr_gt_d = 1'b1;
      clr_sc_d = 1'b1;
    end
    if (rst_score_edge) begin
      clr_gt_d = 1'b1;
      clr_sc_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rst_edge) begin
      state_d = StCountdown;
    end else begin
      unique case (state_q)
        StCountdown: if (!clr_cd_q && cd_sec >= CdLen) state_d = StPlaying;
        StPlaying:   if (!clr_gt_q && gt_sec >= GameLen) state_d = StGameOver;
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    diff_d = diff_q;
    if (state_q == StIdle || state_q == StGameOver) begin
      unique case (btn_difficulty)
        2'b01:   diff_d = DiffEasy;
        2'b10:   diff_d = DiffMedium;
        2'b11:   diff_d = DiffHard;
        default: diff_d = diff_q;
      endcase
    end
  end

  always_comb begin
    enable_countdown        = 1'b0;
    enable_game_timer       = 1'b0;
    enable_score            = 1'b0;
    enable_mole_ctrl        = 1'b0;
    enable_difficulty_timer = 1'b0;
    display_value           = 8'd0;
    display_mode            = 1'b0;
    unique case (state_q)
      StCountdown: begin
        enable_countdown = !clr_cd_q;
        display_value    = (cd_sec >= CdLen) ? 8'd0 : CdLen - cd_sec;
      end
      StPlaying: begin
        enable_game_timer       = !clr_gt_q;
        enable_score            = !clr_sc_q;
        enable_mole_ctrl        = 1'b1;
        enable_difficulty_timer = 1'b1;
        display_value           = score;
        display_mode            = 1'b1;
      end
      StGameOver: begin
        display_value = score;
        display_mode  = 1'b1;
      end
      default: ;
    endcase
  end

  assign clear_countdown  = clr_cd_q;
  assign clear_game_timer = clr_gt_q;
  assign clear_score      = clr_sc_q;
  assign difficulty_level = diff_q;
  assign game_state       = state_q;

endmodule

// File: tb/tb_game_control_fsm.sv
// Directed bench for game_control_fsm with hand-computed expectations.
module tb_game_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_1hz;
  logic       btn_reset;
  logic       btn_reset_score;
  logic [1:0] btn_difficulty;
  logic       timeout_pulse;
  logic       hit_pulse;
  logic [5:0] countdown_sec;
  logic [5:0] game_time_sec;
  logic [7:0] score;
  logic       enable_countdown;
  logic       clear_countdown;
  logic       enable_game_timer;
  logic       clear_game_timer;
  logic       enable_score;
  logic       clear_score;
  logic       enable_mole_ctrl;
  logic       enable_difficulty_timer;
  logic [1:0] difficulty_level;
  logic [7:0] display_value;
  logic       display_mode;
  logic [1:0] game_state;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  game_control_fsm dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .clk_1hz                 (clk_1hz),
    .btn_reset               (btn_reset),
    .btn_reset_score         (btn_reset_score),
    .btn_difficulty          (btn_difficulty),
    .timeout_pulse           (timeout_pulse),
    .hit_pulse               (hit_pulse),
    .countdown_sec           (countdown_sec),
    .game_time_sec           (game_time_sec),
    .score                   (score),
    .enable_countdown        (enable_countdown),
    .clear_countdown         (clear_countdown),
    .enable_game_timer       (enable_game_timer),
    .clear_game_timer        (clear_game_timer),
    .enable_score            (enable_score),
    .clear_score             (clear_score),
    .enable_mole_ctrl        (enable_mole_ctrl),
    .enable_difficulty_timer (enable_difficulty_timer),
    .difficulty_level        (difficulty_level),
    .display_value           (display_value),
    .display_mode            (display_mode),
    .game_state              (game_state)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Packs all enables and clears: {en_cd, clr_cd, en_gt, clr_gt, en_sc, clr_sc, en_mole, en_diff}
  function automatic logic [7:0] ctl();
    return {enable_countdown, clear_countdown, enable_game_timer, clear_game_timer,
            enable_score, clear_score, enable_mole_ctrl, enable_difficulty_timer};
  endfunction

  initial begin
    rst_n = 1'b0;
    clk_1hz = 1'b0;
    btn_reset = 1'b0;
    btn_reset_score = 1'b0;
    btn_difficulty = 2'b00;
    timeout_pulse = 1'b0;
    hit_pulse = 1'b0;
    countdown_sec = 6'd0;
    game_time_sec = 6'd0;
    score = 8'd0;
    #12;
    check("reset_state", {6'd0, game_state}, 8'h00);
    check("reset_ctl", ctl(), 8'h00);
    rst_n = 1'b1;
    tick(2);
    check("idle_state", {6'd0, game_state}, 8'h00);
    check("idle_ctl", ctl(), 8'h00);
    check("idle_disp", display_value, 8'd0);
    check("idle_mode", {7'd0, display_mode}, 8'd0);
    check("idle_diff", {6'd0, difficulty_level}, 8'd0);

    // Start: three-clock press, counters already at zero.
    btn_reset = 1'b1;
    tick(1);
    check("start_state", {6'd0, game_state}, 8'h01);
    check("start_ctl", ctl(), 8'b0101_0100);
    tick(1);
    check("start_cleared", ctl(), 8'b1000_0000);
    tick(1);
    btn_reset = 1'b0;
    check("held_once", ctl(), 8'b1000_0000);
    for (int i = 0; i < 5; i++) begin
      countdown_sec = 6'(i);
      #1;
      check("cd_disp", display_value, 8'(5 - i));
      check("cd_mode", {7'd0, display_mode}, 8'd0);
    end
    tick(1);
    check("cd_not_done", {6'd0, game_state}, 8'h01);

    // Countdown expiry.
    countdown_sec = 6'd5;
    #1;
    check("cd_sat_disp", display_value, 8'd0);
    tick(1);
    check("play_state", {6'd0, game_state}, 8'h02);
    check("play_ctl", ctl(), 8'b0010_1011);
    score = 8'd10;
    #1;
    check("play_disp10", display_value, 8'd10);
    check("play_mode", {7'd0, display_mode}, 8'd1);
    score = 8'd25;
    #1;
    check("play_disp25", display_value, 8'd25);
    btn_difficulty = 2'b11;
    tick(1);
    check("diff_ignored_play", {6'd0, difficulty_level}, 8'd0);
    btn_difficulty = 2'b00;

    // Round end boundary.
    game_time_sec = 6'd29;
    tick(1);
    check("gt29_state", {6'd0, game_state}, 8'h02);
    game_time_sec = 6'd30;
    tick(1);
    check("over_state", {6'd0, game_state}, 8'h03);
    check("over_ctl", ctl(), 8'h00);
    check("over_disp", display_value, 8'd25);
    check("over_mode", {7'd0, display_mode}, 8'd1);
    btn_difficulty = 2'b01;
    tick(1);
    check("diff_easy", {6'd0, difficulty_level}, 8'd0);
    btn_difficulty = 2'b10;
    tick(1);
    check("diff_medium", {6'd0, difficulty_level}, 8'd1);
    btn_difficulty = 2'b11;
    tick(1);
    check("diff_hard", {6'd0, difficulty_level}, 8'd2);
    btn_difficulty = 2'b00;
    tick(1);
    check("diff_hold", {6'd0, difficulty_level}, 8'd2);

    // Restart and return to PLAYING for the score-clear handshake.
    score = 8'd0;
    game_time_sec = 6'd0;
    countdown_sec = 6'd0;
    btn_reset = 1'b1;
    tick(1);
    btn_reset = 1'b0;
    check("restart_state", {6'd0, game_state}, 8'h01);
    tick(1);
    countdown_sec = 6'd5;
    tick(1);
    check("replay_state", {6'd0, game_state}, 8'h02);
    score = 8'd20;
    game_time_sec = 6'd15;
    btn_reset_score = 1'b1;
    tick(1);
    btn_reset_score = 1'b0;
    check("rs_ctl", ctl(), 8'b0001_0111);
    check("rs_state", {6'd0, game_state}, 8'h02);
    tick(2);
    check("rs_held", ctl(), 8'b0001_0111);
    score = 8'd0;
    game_time_sec = 6'd0;
    tick(1);
    check("rs_dropped", ctl(), 8'b0010_1011);

    // Restart from PLAYING: countdown clear must block advance until it reads zero.
    countdown_sec = 6'd2;
    game_time_sec = 6'd10;
    btn_reset = 1'b1;
    tick(1);
    btn_reset = 1'b0;
    check("rp_state", {6'd0, game_state}, 8'h01);
    check("rp_ctl", ctl(), 8'b0101_0100);
    countdown_sec = 6'd5;
    tick(2);
    check("rp_blocked", {6'd0, game_state}, 8'h01);
    check("rp_blocked_ctl", ctl(), 8'b0101_0000);
    countdown_sec = 6'd0;
    tick(1);
    check("rp_released", ctl(), 8'b1001_0000);
    check("rp_disp", display_value, 8'd5);

    // Simultaneous edges: union of clears, reset action wins.
    score = 8'd3;
    btn_reset = 1'b1;
    btn_reset_score = 1'b1;
    countdown_sec = 6'd1;
    tick(1);
    btn_reset = 1'b0;
    btn_reset_score = 1'b0;
    check("both_state", {6'd0, game_state}, 8'h01);
    check("both_ctl", ctl(), 8'b0101_0100);

    // Asynchronous reset without a clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_state", {6'd0, game_state}, 8'h00);
    check("async_ctl", ctl(), 8'h00);
    check("async_diff", {6'd0, difficulty_level}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
